alu_sequencer: RTL and testbench

- Initiator side of the CPU ALU interface. Accepts one decoded ALU instruction per valid/ready handshake.
- Fetches operands from the register file, or takes an immediate for operand B.
- Drives the ALU operand, opcode and active lines for exactly one cycle, then captures the result.
- Writes the result back to the register file, or reports compare flags. Sits between the decode stage and the ALU/register file in the CPU datapath.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_sequencer_if.sv | 43 ++++
 rtl/alu_sequencer.sv | 97 +++++++++
 tb/tb_alu_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, flag bit positions and sequencer state encoding.
package alu_pkg;
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_MUL = 4'b0010;
   localparam logic [3:0] ALU_AND = 4'b0011;
   localparam logic [3:0] ALU_OR  = 4'b0100;
   localparam logic [3:0] ALU_XOR = 4'b0101;
   localparam logic [3:0] ALU_NOT = 4'b0110;
   localparam logic [3:0] ALU_NEG = 4'b0111;
   localparam logic [3:0] ALU_CMP = 4'b1000;
   localparam int FLAG_EQ = 0;
   localparam int FLAG_LT = 1;
   localparam int FLAG_GT = 2;
   typedef enum logic [1:0] {IDLE, READ, EXEC, WB} seq_state_t;
endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: request handshake plus register-file and ALU buses of the sequencer.
interface alu_sequencer_if #(
   parameter int DATA_WIDTH     = 16,
   parameter int OPCODE_WIDTH   = 4,
   parameter int REG_ADDR_WIDTH = 3
);
   logic                      req_valid;
   logic                      req_ready;
   logic [OPCODE_WIDTH-1:0]   req_opcode;
   logic [REG_ADDR_WIDTH-1:0] req_rd;
   logic [REG_ADDR_WIDTH-1:0] req_ra;
   logic [REG_ADDR_WIDTH-1:0] req_rb;
   logic                      req_imm_sel;
   logic [DATA_WIDTH-1:0]     req_imm;
   logic [REG_ADDR_WIDTH-1:0] rf_ra_addr;
   logic [REG_ADDR_WIDTH-1:0] rf_rb_addr;
   logic [DATA_WIDTH-1:0]     rf_ra_data;
   logic [DATA_WIDTH-1:0]     rf_rb_data;
   logic                      rf_we;
   logic [REG_ADDR_WIDTH-1:0] rf_wa;
   logic [DATA_WIDTH-1:0]     rf_wd;
   logic [DATA_WIDTH-1:0]     alu_op_a;
   logic [DATA_WIDTH-1:0]     alu_op_b;
   logic [OPCODE_WIDTH-1:0]   alu_opcode;
   logic                      alu_active;
   logic [DATA_WIDTH-1:0]     alu_result;
   logic                      alu_equal;
   logic                      alu_less;
   logic                      alu_greater;
   // master is the sequencer; slave is the decode stage, register file and ALU around it
   modport master (
      input  req_valid, req_opcode, req_rd, req_ra, req_rb, req_imm_sel, req_imm,
      input  rf_ra_data, rf_rb_data, alu_result, alu_equal, alu_less, alu_greater,
      output req_ready, rf_ra_addr, rf_rb_addr, rf_we, rf_wa, rf_wd,
      output alu_op_a, alu_op_b, alu_opcode, alu_active
   );
   modport slave (
      output req_valid, req_opcode, req_rd, req_ra, req_rb, req_imm_sel, req_imm,
      output rf_ra_data, rf_rb_data, alu_result, alu_equal, alu_less, alu_greater,
      input  req_ready, rf_ra_addr, rf_rb_addr, rf_we, rf_wa, rf_wd,
      input  alu_op_a, alu_op_b, alu_opcode, alu_active
   );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetches operands, strobes the ALU for one cycle and writes back or records compare flags.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH     = 16,
   parameter int OPCODE_WIDTH   = 4,
   parameter int REG_ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   alu_sequencer_if.master       bus,
   output logic [2:0]            cmp_flags,
   output logic                  done,
   output logic                  err,
   output logic [15:0]           retired_count
);
   seq_state_t                state;
   logic [OPCODE_WIDTH-1:0]   opc_q;
   logic [REG_ADDR_WIDTH-1:0] rd_q, ra_q, rb_q;
   logic                      imm_sel_q;
   logic [DATA_WIDTH-1:0]     imm_q, op_a_q, op_b_q, res_q;
   logic [2:0]                cmp_q, flags_now;
   logic                      legal, writes, is_cmp;
   assign legal  = opc_q <= OPCODE_WIDTH'(ALU_CMP);
   assign writes = opc_q <= OPCODE_WIDTH'(ALU_NEG);
   assign is_cmp = opc_q == OPCODE_WIDTH'(ALU_CMP);
   assign bus.req_ready  = state == IDLE;
   assign bus.rf_ra_addr = ra_q;
   assign bus.rf_rb_addr = rb_q;
   assign bus.rf_wa      = rd_q;
   assign bus.rf_wd      = res_q;
   assign bus.alu_op_a   = op_a_q;
   assign bus.alu_op_b   = op_b_q;
   assign bus.alu_opcode = opc_q;
   always_comb begin
      flags_now          = '0;
      flags_now[FLAG_EQ] = bus.alu_equal;
      flags_now[FLAG_LT] = bus.alu_less;
      flags_now[FLAG_GT] = bus.alu_greater;
   end
   // ALU flags were updated at the end of EXEC, so they are live during WB of a compare
   assign cmp_flags = (state == WB && is_cmp) ? flags_now : cmp_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         opc_q          <= '0;
         rd_q           <= '0;
         ra_q           <= '0;
         rb_q           <= '0;
         imm_sel_q      <= 1'b0;
         imm_q          <= '0;
         op_a_q         <= '0;
         op_b_q         <= '0;
         res_q          <= '0;
         cmp_q          <= '0;
         retired_count  <= '0;
         bus.rf_we      <= 1'b0;
         bus.alu_active <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
      end else begin
         bus.rf_we      <= 1'b0;
         bus.alu_active <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
         case (state)
            IDLE: if (bus.req_valid) begin
               opc_q     <= bus.req_opcode;
               rd_q      <= bus.req_rd;
               ra_q      <= bus.req_ra;
               rb_q      <= bus.req_rb;
               imm_sel_q <= bus.req_imm_sel;
               imm_q     <= bus.req_imm;
               state     <= READ;
            end
            READ: begin
               op_a_q         <= bus.rf_ra_data;
               op_b_q         <= imm_sel_q ? imm_q : bus.rf_rb_data;
               bus.alu_active <= legal;
               state          <= EXEC;
            end
            EXEC: begin
               res_q     <= bus.alu_result;
               bus.rf_we <= writes;
               done      <= 1'b1;
               err       <= !legal;
               state     <= WB;
            end
            WB: begin
               cmp_q         <= cmp_flags;
               retired_count <= err ? retired_count : retired_count + 16'd1;
               state         <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed checks of alu_sequencer against a behavioural register file and ALU.
module tb_alu_sequencer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  cmp_flags;
   logic        done, err;
   logic [15:0] retired_count;
   int          compared = 0;
   int          mismatched = 0;
   logic [15:0] rf [8] = '{default: 16'h0};
   logic        pre_we = 1'b0;
   logic [2:0]  pre_wa = '0;
   logic [15:0] pre_wd = '0;
   logic        eq_f = 1'b0, lt_f = 1'b0, gt_f = 1'b0;
   logic [2:0]  act, cf;
   logic        dn, er, we;
   logic [2:0]  wa;
   logic [15:0] wd;

   alu_sequencer_if bus ();

   alu_sequencer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus.master),
      .cmp_flags     (cmp_flags),
      .done          (done),
      .err           (err),
      .retired_count (retired_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pre_we) rf[pre_wa] <= pre_wd;
      else if (bus.rf_we) rf[bus.rf_wa] <= bus.rf_wd;
   end
   assign bus.rf_ra_data = rf[bus.rf_ra_addr];
   assign bus.rf_rb_data = rf[bus.rf_rb_addr];

   always_comb begin
      case (bus.alu_opcode)
         4'd0: bus.alu_result = bus.alu_op_a + bus.alu_op_b;
         4'd1: bus.alu_result = bus.alu_op_a - bus.alu_op_b;
         4'd2: bus.alu_result = bus.alu_op_a * bus.alu_op_b;
         4'd3: bus.alu_result = bus.alu_op_a & bus.alu_op_b;
         4'd4: bus.alu_result = bus.alu_op_a | bus.alu_op_b;
         4'd5: bus.alu_result = bus.alu_op_a ^ bus.alu_op_b;
         4'd6: bus.alu_result = ~bus.alu_op_a;
         4'd7: bus.alu_result = -bus.alu_op_a;
         default: bus.alu_result = 16'h0;
      endcase
   end
   always @(posedge clk) if (bus.alu_active) begin
      eq_f <= bus.alu_op_a == bus.alu_op_b;
      lt_f <= bus.alu_op_a < bus.alu_op_b;
      gt_f <= bus.alu_op_a > bus.alu_op_b;
   end
   assign bus.alu_equal   = eq_f;
   assign bus.alu_less    = lt_f;
   assign bus.alu_greater = gt_f;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [2:0] a, input logic [15:0] d);
      pre_we = 1'b1; pre_wa = a; pre_wd = d;
      tick();
      pre_we = 1'b0;
   endtask

   // issues one instruction from IDLE and records what the DUT shows in READ, EXEC and WB
   task automatic run_instr(input logic [3:0] opc, input logic [2:0] rd, ra, rb,
                            input logic isel, input logic [15:0] imm);
      bus.req_valid = 1'b1; bus.req_opcode = opc; bus.req_rd = rd;
      bus.req_ra = ra; bus.req_rb = rb; bus.req_imm_sel = isel; bus.req_imm = imm;
      tick();
      bus.req_valid = 1'b0;
      act[0] = bus.alu_active;
      tick();
      act[1] = bus.alu_active;
      tick();
      act[2] = bus.alu_active;
      dn = done; er = err; we = bus.rf_we; wa = bus.rf_wa; wd = bus.rf_wd; cf = cmp_flags;
      tick();
   endtask

   task automatic test_reset();
      compared++; if (bus.req_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
      compared++; if (retired_count !== 16'd0) begin mismatched++; $display("FAIL reset_retired: got %0d want 0", retired_count); end
      compared++; if (cmp_flags !== 3'b000) begin mismatched++; $display("FAIL reset_cmp: got %b want 000", cmp_flags); end
      compared++; if ({done, err, bus.rf_we, bus.alu_active} !== 4'b0000) begin mismatched++; $display("FAIL reset_strobes: got %b want 0000", {done, err, bus.rf_we, bus.alu_active}); end
   endtask

   task automatic test_add();
      preload(3'd1, 16'd5);
      preload(3'd2, 16'd7);
      run_instr(4'b0000, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0);
      compared++; if (act !== 3'b010) begin mismatched++; $display("FAIL add_active: got %b want 010", act); end
      compared++; if ({dn, er, we} !== 3'b101) begin mismatched++; $display("FAIL add_done_err_we: got %b want 101", {dn, er, we}); end
      compared++; if (wa !== 3'd3) begin mismatched++; $display("FAIL add_wa: got %0d want 3", wa); end
      compared++; if (wd !== 16'd12) begin mismatched++; $display("FAIL add_wd: got %0d want 12", wd); end
      compared++; if (retired_count !== 16'd1) begin mismatched++; $display("FAIL add_retired: got %0d want 1", retired_count); end
      compared++; if (rf[3] !== 16'd12) begin mismatched++; $display("FAIL add_r3: got %0d want 12", rf[3]); end
   endtask

   task automatic test_sub_wrap();
      preload(3'd1, 16'd3);
      preload(3'd2, 16'd5);
      run_instr(4'b0001, 3'd1, 3'd1, 3'd2, 1'b0, 16'h0);
      compared++; if ({dn, we, wa} !== {1'b1, 1'b1, 3'd1}) begin mismatched++; $display("FAIL sub_we_wa: got %b want 11001", {dn, we, wa}); end
      compared++; if (wd !== 16'hFFFE) begin mismatched++; $display("FAIL sub_wd: got %h want fffe", wd); end
      compared++; if (rf[1] !== 16'hFFFE) begin mismatched++; $display("FAIL sub_r1: got %h want fffe", rf[1]); end
      compared++; if (retired_count !== 16'd2) begin mismatched++; $display("FAIL sub_retired: got %0d want 2", retired_count); end
   endtask

   task automatic test_cmp_imm();
      logic [15:0] imms [3] = '{16'd9, 16'd10, 16'd2};
      logic [2:0]  exps [3] = '{3'b001, 3'b010, 3'b100};
      preload(3'd4, 16'd9);
      for (int i = 0; i < 3; i++) begin
         run_instr(4'b1000, 3'd5, 3'd4, 3'd0, 1'b1, imms[i]);
         compared++; if (cf !== exps[i]) begin mismatched++; $display("FAIL cmp_flags_%0d: got %b want %b", i, cf, exps[i]); end
         compared++; if ({act, dn, er, we} !== 6'b010100) begin mismatched++; $display("FAIL cmp_strobes_%0d: got %b want 010100", i, {act, dn, er, we}); end
      end
      compared++; if (cmp_flags !== 3'b100) begin mismatched++; $display("FAIL cmp_hold: got %b want 100", cmp_flags); end
      compared++; if (retired_count !== 16'd5) begin mismatched++; $display("FAIL cmp_retired: got %0d want 5", retired_count); end
   endtask

   task automatic test_illegal();
      run_instr(4'b1010, 3'd2, 3'd1, 3'd2, 1'b0, 16'h0);
      compared++; if ({act, dn, er, we} !== 6'b000110) begin mismatched++; $display("FAIL ill_strobes: got %b want 000110", {act, dn, er, we}); end
      compared++; if (cf !== 3'b100) begin mismatched++; $display("FAIL ill_cmp_wb: got %b want 100", cf); end
      compared++; if (retired_count !== 16'd5) begin mismatched++; $display("FAIL ill_retired: got %0d want 5", retired_count); end
      compared++; if (cmp_flags !== 3'b100) begin mismatched++; $display("FAIL ill_cmp: got %b want 100", cmp_flags); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] rdy, dns;
      logic [15:0] wd2, wd6;
      preload(3'd5, 16'd1);
      preload(3'd6, 16'd2);
      bus.req_valid = 1'b1; bus.req_opcode = 4'b0000; bus.req_rd = 3'd7;
      bus.req_ra = 3'd5; bus.req_rb = 3'd6; bus.req_imm_sel = 1'b0; bus.req_imm = 16'h0;
      wd2 = '0; wd6 = '0;
      for (int i = 0; i < 8; i++) begin
         tick();
         rdy[i] = bus.req_ready; dns[i] = done;
         if (i == 0) begin bus.req_rd = 3'd0; bus.req_ra = 3'd7; bus.req_rb = 3'd5; end
         if (i == 4) bus.req_valid = 1'b0;
         if (i == 2) wd2 = bus.rf_wd;
         if (i == 6) wd6 = bus.rf_wd;
      end
      compared++; if (rdy !== 8'b1000_1000) begin mismatched++; $display("FAIL b2b_ready: got %b want 10001000", rdy); end
      compared++; if (dns !== 8'b0100_0100) begin mismatched++; $display("FAIL b2b_done: got %b want 01000100", dns); end
      compared++; if ({wd2, wd6} !== {16'd3, 16'd4}) begin mismatched++; $display("FAIL b2b_wd: got %0d,%0d want 3,4", wd2, wd6); end
      compared++; if (retired_count !== 16'd7) begin mismatched++; $display("FAIL b2b_retired: got %0d want 7", retired_count); end
      compared++; if (rf[0] !== 16'd4) begin mismatched++; $display("FAIL b2b_r0: got %0d want 4", rf[0]); end
   endtask

   task automatic test_reset_midop();
      bus.req_valid = 1'b1; bus.req_opcode = 4'b0000; bus.req_rd = 3'd2;
      bus.req_ra = 3'd5; bus.req_rb = 3'd6; bus.req_imm_sel = 1'b0;
      tick();
      bus.req_valid = 1'b0;
      tick();
      compared++; if (bus.alu_active !== 1'b1) begin mismatched++; $display("FAIL mid_exec_active: got %b want 1", bus.alu_active); end
      #2 rst_n = 1'b0;
      #1;
      compared++; if ({bus.req_ready, bus.alu_active, bus.rf_we, done} !== 4'b1000) begin mismatched++; $display("FAIL mid_async: got %b want 1000", {bus.req_ready, bus.alu_active, bus.rf_we, done}); end
      tick();
      compared++; if ({bus.rf_we, done} !== 2'b00) begin mismatched++; $display("FAIL mid_held: got %b want 00", {bus.rf_we, done}); end
      @(negedge clk) rst_n = 1'b1;
      tick();
      compared++; if ({bus.req_ready, cmp_flags} !== 4'b1000) begin mismatched++; $display("FAIL mid_after_ready_cmp: got %b want 1000", {bus.req_ready, cmp_flags}); end
      compared++; if (retired_count !== 16'd0) begin mismatched++; $display("FAIL mid_retired: got %0d want 0", retired_count); end
      compared++; if (rf[2] !== 16'd5) begin mismatched++; $display("FAIL mid_r2: got %0d want 5", rf[2]); end
   endtask

   initial begin
      bus.req_valid = 1'b0; bus.req_opcode = '0; bus.req_rd = '0;
      bus.req_ra = '0; bus.req_rb = '0; bus.req_imm_sel = 1'b0; bus.req_imm = '0;
      #12 rst_n = 1'b1;
      tick();
      test_reset();
      test_add();
      test_sub_wrap();
      test_cmp_imm();
      test_illegal();
      test_back_to_back();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
